// File: rtl/qrd_delay_pkg.sv
// Shared constants and helpers for the programmable delay line.
// Width derivation and latency clamping live here so every user agrees.
package qrd_delay_pkg;

  localparam int DATA_LENGTH_D   = 8;
  localparam int CHANNELS_D      = 4;
  localparam int MAX_DELAY_D     = 32;
  localparam int DEFAULT_DELAY_D = 19;

  // Bits needed to hold 0..max inclusive.
  function automatic int dly_w_f(input int max);
    int w;
    w = 1;
    while ((1 << w) < (max + 1)) w++;
    return w;
  endfunction

  // Legal latency is 1..max; out-of-range requests saturate.
  function automatic int dly_clamp(input int sel, input int max);
    if (sel < 1)   return 1;
    if (sel > max) return max;
    return sel;
  endfunction

endpackage

// File: rtl/dly_tap_sreg.sv
// Enable shift register with async reset, synchronous clear
// and a tap mux driven by a registered select from the parent.
module dly_tap_sreg
  import qrd_delay_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 32,
  parameter int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [W-1:0]     d_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [W-1:0]     q_o
);

  logic [W-1:0] q_q [DEPTH];

  // Clear wins over shift; otherwise advance one stage per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) q_q[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) q_q[k] <= '0;
    end else if (en_i) begin
      q_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) q_q[k] <= q_q[k-1];
    end
  end

  assign q_o = q_q[sel_i];

endmodule

// File: rtl/delay_line_prog.sv
// Multi-lane programmable delay line: all lanes share one latency,
// valid tags flush on demand, and a settle counter flags refill.
module delay_line_prog
  import qrd_delay_pkg::*;
#(
  parameter int DATA_LENGTH   = DATA_LENGTH_D,
  parameter int CHANNELS      = CHANNELS_D,
  parameter int MAX_DELAY     = MAX_DELAY_D,
  parameter int DEFAULT_DELAY = DEFAULT_DELAY_D,
  parameter int DLY_W         = dly_w_f(MAX_DELAY)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            flush,
  input  logic                            dly_load,
  input  logic [DLY_W-1:0]                dly_sel,
  input  logic [CHANNELS*DATA_LENGTH-1:0] din,
  input  logic                            din_valid,
  output logic [CHANNELS*DATA_LENGTH-1:0] dout,
  output logic                            dout_valid,
  output logic [DLY_W-1:0]                dly_cur,
  output logic                            busy
);

  localparam int DW    = CHANNELS * DATA_LENGTH;
  localparam int TAP_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [DLY_W-1:0] sel_clamp;
  logic             vclr;
  logic [0:0]       vq;

  assign sel_clamp = DLY_W'(dly_clamp(int'(dly_sel), MAX_DELAY));

  // A load implies a flush so stale samples never leave at the new tap.
  assign vclr = flush | dly_load;

  // Next latency, tap index and settle count.
  always_comb begin
    dly_d = dly_q;
    tap_d = tap_q;
    cnt_d = cnt_q;
    if (dly_load) begin
      dly_d = sel_clamp;
      tap_d = TAP_W'(sel_clamp - DLY_W'(1));
      cnt_d = sel_clamp;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DLY_W'(1);
    end
  end

  // Latency control state; tap index kept pre-decoded for the muxes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= DLY_W'(DEFAULT_DELAY);
      tap_q <= TAP_W'(DEFAULT_DELAY - 1);
      cnt_q <= '0;
    end else begin
      dly_q <= dly_d;
      tap_q <= tap_d;
      cnt_q <= cnt_d;
    end
  end

  dly_tap_sreg #(
    .W     (DW),
    .DEPTH (MAX_DELAY),
    .SEL_W (TAP_W)
  ) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .clr_i (1'b0),
    .d_i   (din),
    .sel_i (tap_q),
    .q_o   (dout)
  );

  dly_tap_sreg #(
    .W     (1),
    .DEPTH (MAX_DELAY),
    .SEL_W (TAP_W)
  ) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .clr_i (vclr),
    .d_i   (din_valid),
    .sel_i (tap_q),
    .q_o   (vq)
  );

  assign dout_valid = vq[0];
  assign dly_cur    = dly_q;
  assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed bench for delay_line_prog with a history-based model
// and per-cycle comparison plus literal spot checks.
module tb_delay_line_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, flush, dly_load, din_valid;
  logic [5:0]  dly_sel;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid, busy;
  logic [5:0]  dly_cur;

  int nvec = 0;
  int nerr = 0;

  delay_line_prog dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .dly_load   (dly_load),
    .dly_sel    (dly_sel),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dly_cur    (dly_cur),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model: every enabled edge appends to a history; output is the
  // entry written cur edges ago, valid only if written after the
  // latest flush/load and after the latest reset.
  logic [31:0] hd [0:4095];
  bit          hv [0:4095];
  int n = 0, fmark = 0, rbase = 0, cur = 19, cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbase = n;
      fmark = n;
      cur   = 19;
      cnt   = 0;
    end else begin
      if (en) begin
        n = n + 1;
        hd[n] = din;
        hv[n] = din_valid;
      end
      if (flush || dly_load) fmark = n;
      if (dly_load) begin
        cur = (dly_sel == 0) ? 1 : (dly_sel > 32) ? 32 : int'(dly_sel);
        cnt = cur;
      end else if (en && cnt > 0) begin
        cnt = cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int idx;
    logic [31:0] ed;
    logic ev;
    idx = n - cur + 1;
    if (idx <= rbase) begin
      ed = '0;
      ev = 1'b0;
    end else begin
      ed = hd[idx];
      ev = hv[idx] && (idx > fmark);
    end
    chk("m_dout", dout, ed);
    chk("m_vld", {31'd0, dout_valid}, {31'd0, ev});
    chk("m_cur", {26'd0, dly_cur}, cur);
    chk("m_busy", {31'd0, busy}, {31'd0, cnt != 0});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; en = 0; flush = 0; dly_load = 0;
    dly_sel = 0; din = 0; din_valid = 0;
    repeat (3) tick();
    chk("rst_cur", {26'd0, dly_cur}, 32'd19);
    rst_n = 1'b1;

    // Default latency 19: single valid sample, one-cycle pulse.
    en = 1; din = 32'hA1B2C3D4; din_valid = 1;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (k == 0) begin din = 0; din_valid = 0; end
      chk("lat_v", {31'd0, dout_valid}, {31'd0, k == 18});
      if (k == 18) chk("lat_d", dout, 32'hA1B2C3D4);
    end

    // Program latency 3 then ramp.
    dly_load = 1; dly_sel = 3;
    tick();
    dly_load = 0; din = 1; din_valid = 1;
    chk("prg_busy0", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      din = i + 1;
      chk("prg_busy", {31'd0, busy}, {31'd0, i < 3});
      chk("prg_v", {31'd0, dout_valid}, {31'd0, i == 3});
      if (i == 3) chk("prg_d", dout, 32'd1);
    end
    tick();
    chk("prg_d2", dout, 32'd2);
    dly_load = 1; dly_sel = 0;
    tick();
    chk("clamp_lo", {26'd0, dly_cur}, 32'd1);
    dly_sel = 40;
    tick();
    chk("clamp_hi", {26'd0, dly_cur}, 32'd32);
    dly_load = 0;

    // Stall: latency 4, hold en low for 5 cycles at age 2.
    din_valid = 0; din = 0;
    dly_load = 1; dly_sel = 4;
    tick();
    dly_load = 0;
    repeat (4) tick();
    chk("stl_busy", {31'd0, busy}, 32'd0);
    din = 32'h11; din_valid = 1;
    tick();
    din = 0; din_valid = 0;
    tick();
    en = 0;
    held = dout;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stl_hold", dout, held);
      chk("stl_v", {31'd0, dout_valid}, 32'd0);
    end
    en = 1;
    tick();
    chk("stl_v3", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("stl_v4", {31'd0, dout_valid}, 32'd1);
    chk("stl_d4", dout, 32'h11);
    tick();
    chk("stl_v5", {31'd0, dout_valid}, 32'd0);

    // Flush with 10 samples in flight at latency 8.
    dly_load = 1; dly_sel = 8;
    tick();
    dly_load = 0;
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      din = 32'h20 + i; din_valid = 1;
      tick();
    end
    flush = 1; din = 32'hEE; din_valid = 1;
    tick();
    flush = 0; din_valid = 0; din = 0;
    chk("fl_v0", {31'd0, dout_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("fl_v", {31'd0, dout_valid}, 32'd0);
      chk("fl_cur", {26'd0, dly_cur}, 32'd8);
    end
    din = 32'h77; din_valid = 1;
    repeat (9) tick();
    chk("fl_rec", {31'd0, dout_valid}, 32'd1);

    // Load+flush with en low, then reload while busy.
    en = 0; dly_load = 1; flush = 1; dly_sel = 10;
    tick();
    chk("c_cur", {26'd0, dly_cur}, 32'd10);
    chk("c_busy", {31'd0, busy}, 32'd1);
    dly_load = 0; flush = 0; en = 1; din_valid = 1;
    for (int i = 0; i < 2; i++) begin
      din = 32'h100 + i;
      tick();
    end
    dly_load = 1; dly_sel = 6; din = 32'h1FF;
    tick();
    dly_load = 0;
    for (int i = 1; i <= 6; i++) begin
      din = 32'h200 + i;
      tick();
      chk("c_busy2", {31'd0, busy}, {31'd0, i < 6});
      chk("c_cur2", {26'd0, dly_cur}, 32'd6);
      chk("c_v2", {31'd0, dout_valid}, {31'd0, i == 6});
      if (i == 6) chk("c_d2", dout, 32'h201);
    end

    // Async reset mid-stream at latency 5 with the line full.
    dly_load = 1; dly_sel = 5;
    tick();
    dly_load = 0;
    for (int i = 0; i < 10; i++) begin
      din = 32'h300 + i; din_valid = 1;
      tick();
    end
    chk("r_pre", {31'd0, dout_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_dout", dout, 32'd0);
    chk("r_v", {31'd0, dout_valid}, 32'd0);
    chk("r_cur", {26'd0, dly_cur}, 32'd19);
    chk("r_busy", {31'd0, busy}, 32'd0);
    tick();
    en = 0; din_valid = 0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("r_after", dout, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
